// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Segment codes are active low, bit order [6:0] = A..G.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK   = 4'hF;
  localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // Position of the low anode; only meaningful when exactly one is low.
  function automatic logic [1:0] anode_index(input logic [3:0] an_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!an_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_decode.sv
// Combinational segment pattern to BCD digit decoder.
// Unknown patterns decode as illegal; all-off decodes as blank.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_segs,
  output logic [3:0] o_digit,
  output logic       o_is_blank,
  output logic       o_is_bad
);

  always_comb begin
    o_digit    = DIGIT_ILLEGAL;
    o_is_blank = 1'b0;
    o_is_bad   = 1'b0;
    case (i_segs)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_BLANK: begin
        o_digit    = DIGIT_BLANK;
        o_is_blank = 1'b1;
      end
      default:   o_is_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers digits, blanks and decimal points from a multiplexed
// active-low 4-digit display bus and publishes confirmed frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int CONFIRM_FRAMES = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodes,
  input  logic [6:0]  segs,
  input  logic        decimalPt,
  output logic [15:0] q,
  output logic [3:0]  blank,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        anode_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CONF_MAX    = CW'(CONFIRM_FRAMES);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]       r_an;
  logic [6:0]       r_sg;
  logic             r_dpn;
  logic [11:0]      r_bus_prev;

  state_t           r_state;
  state_t           w_state_nx;
  logic [SW-1:0]    r_settle;
  logic [TW-1:0]    r_to;
  logic [CW-1:0]    r_conf;

  logic [3:0][3:0]  r_wd;
  logic [3:0]       r_wb;
  logic [3:0]       r_wdp;
  logic [3:0]       r_seen;
  logic [3:0][3:0]  r_pd;
  logic [3:0]       r_pb;
  logic [3:0]       r_pdp;
  logic             r_prev_ok;

  logic [11:0]      w_bus;
  logic             w_changed;
  logic [2:0]       w_nlow;
  logic             w_one;
  logic             w_multi;
  logic [1:0]       w_idx;
  logic [3:0]       w_digit;
  logic             w_is_blank;
  logic             w_is_bad;
  logic             w_capture;
  logic             w_settle_inc;
  logic             w_frame;
  logic             w_same;
  logic [CW-1:0]    w_conf_nx;
  logic             w_publish;
  logic             w_to_inc;
  logic             w_to_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an       <= 4'hF;
      r_sg       <= 7'h7F;
      r_dpn      <= 1'b1;
      r_bus_prev <= 12'hFFF;
    end else begin
      r_an       <= anodes;
      r_sg       <= segs;
      r_dpn      <= decimalPt;
      r_bus_prev <= w_bus;
    end
  end

  assign w_bus     = {r_an, r_sg, r_dpn};
  assign w_changed = (w_bus != r_bus_prev);
  assign w_nlow    = 3'($countones(~r_an));
  assign w_one     = (w_nlow == 3'd1);
  assign w_multi   = (w_nlow > 3'd1);
  assign w_idx     = anode_index(r_an);

  seg7_pattern_decode u_decode (
    .i_segs     (r_sg),
    .o_digit    (w_digit),
    .o_is_blank (w_is_blank),
    .o_is_bad   (w_is_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_one) w_state_nx = SETTLE;
      end
      SETTLE: begin
        if (!w_one)
          w_state_nx = IDLE;
        else if (!w_changed && r_settle == SETTLE_LAST)
          w_state_nx = HOLD;
      end
      HOLD: begin
        if (!w_one)         w_state_nx = IDLE;
        else if (w_changed) w_state_nx = SETTLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_capture    = 1'b0;
    w_settle_inc = 1'b0;
    w_to_inc     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_to_inc = !w_one && (r_to != TO_MAX);
      end
      SETTLE: begin
        if (w_one && !w_changed) begin
          w_capture    = (r_settle == SETTLE_LAST);
          w_settle_inc = (r_settle != SETTLE_LAST);
        end
      end
      HOLD: ;
      default: ;
    endcase
  end

  assign w_to_fire = w_to_inc && (r_to == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
      r_to     <= '0;
    end else begin
      r_settle <= w_settle_inc ? r_settle + 1'b1 : '0;
      if (w_one)         r_to <= '0;
      else if (w_to_inc) r_to <= r_to + 1'b1;
    end
  end

  // A frame only counts toward confirmation against a real predecessor.
  assign w_frame   = (r_seen == 4'hF);
  assign w_same    = r_prev_ok && (r_wd == r_pd) &&
                     (r_wb == r_pb) && (r_wdp == r_pdp);
  assign w_conf_nx = !w_same ? CW'(1) :
                     (r_conf == CONF_MAX) ? r_conf : r_conf + 1'b1;
  assign w_publish = w_frame && (w_conf_nx == CONF_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd       <= '0;
      r_wb       <= '0;
      r_wdp      <= '0;
      r_seen     <= '0;
      r_pd       <= '0;
      r_pb       <= '0;
      r_pdp      <= '0;
      r_prev_ok  <= 1'b0;
      r_conf     <= '0;
      q          <= '0;
      blank      <= '0;
      dp         <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      anode_err  <= 1'b0;
    end else begin
      frame_done <= w_frame && !w_to_fire;
      seg_err    <= w_capture && w_is_bad;
      anode_err  <= w_multi;
      if (w_to_fire) begin
        r_seen    <= '0;
        r_conf    <= '0;
        r_prev_ok <= 1'b0;
        valid     <= 1'b0;
      end else if (w_frame) begin
        r_seen    <= '0;
        r_pd      <= r_wd;
        r_pb      <= r_wb;
        r_pdp     <= r_wdp;
        r_prev_ok <= 1'b1;
        r_conf    <= w_conf_nx;
        if (w_publish) begin
          q     <= r_wd;
          blank <= r_wb;
          dp    <= r_wdp;
          valid <= 1'b1;
        end
      end else if (w_capture) begin
        r_wd[w_idx]   <= w_digit;
        r_wb[w_idx]   <= w_is_blank;
        r_wdp[w_idx]  <= ~r_dpn;
        r_seen[w_idx] <= 1'b1;
      end
    end
  end

endmodule
